// File: rtl/program_loader.sv
// ============================================================================
// Module     : program_loader
// Description: Framed byte-stream boot loader. It writes the image big-endian
//              into imem and holds the CPU in reset until the load completes.
//              Optional checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 256,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [7:0]            imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           word_count
);

  localparam logic [16:0]           C_MAX_WORDS = 17'(MAX_WORDS);
  localparam logic [ADDR_WIDTH-1:0] C_BASE      = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [17:0]           cnt_q, cnt_d;
  logic [15:0]           wc_q, wc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  cpu_reset_q;
  logic                  done_q;
  logic                  error_q;
  logic                  w_accept;
  logic [15:0]           w_len;
  state_t                w_end_state;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            chk_q, chk_d;
`endif

  assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CHK);
  assign w_accept = in_valid && in_ready;
  assign w_len    = {wc_q[15:8], in_data};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign w_end_state = S_CHK;
`else
  assign w_end_state = S_DONE;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wc_d    = wc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      S_LEN_HI: begin
        if (w_accept) begin
          wc_d    = {in_data, 8'h00};
          state_d = S_LEN_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          chk_d   = in_data;
`endif
        end
      end
      S_LEN_LO: begin
        if (w_accept) begin
          wc_d = w_len;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          chk_d = chk_q ^ in_data;
`endif
          if ({1'b0, w_len} > C_MAX_WORDS) begin
            state_d = S_ERROR;
          end else if (w_len == 16'd0) begin
            state_d = w_end_state;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_accept) begin
          we_d    = 1'b1;
          addr_d  = C_BASE + cnt_q[ADDR_WIDTH-1:0];
          wdata_d = in_data;
          cnt_d   = cnt_q + 18'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ in_data;
`endif
          // Last byte when the incremented count reaches 4*N.
          if ((cnt_q + 18'd1) == {wc_q, 2'b00}) begin
            state_d = w_end_state;
          end
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) begin
          state_d = (in_data == chk_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      S_DONE, S_ERROR: begin
        if (reload) begin
          state_d = S_LEN_HI;
          cnt_d   = 18'd0;
        end
      end
      default: state_d = S_LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_LEN_HI;
      cnt_q       <= 18'd0;
      wc_q        <= 16'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wc_q        <= wc_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      // Release lags DONE entry by a cycle so the final write lands first.
      cpu_reset_q <= (state_q != S_DONE);
      done_q      <= (state_d == S_DONE);
      error_q     <= (state_d == S_ERROR);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = done_q;
  assign load_error = error_q;
  assign word_count = wc_q;

endmodule

`default_nettype wire
